// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: record kinds, FSM states and the
// classifier that turns one cycle of commit signals into a record payload.
package commit_trace_pkg;

  typedef enum logic [2:0] {
    KIND_REG  = 3'd0,
    KIND_LD   = 3'd1,
    KIND_STU  = 3'd2,
    KIND_ST   = 3'd3,
    KIND_HALT = 3'd4,
    KIND_NOP  = 3'd5
  } kind_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_HALT_PEND = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Everything in a record except the instruction number.
  typedef struct packed {
    kind_t       kind;
    logic [15:0] pc;
    logic [2:0]  rd;
    logic [15:0] rval;
    logic [15:0] addr;
    logic [15:0] mval;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  // Record layout: {kind, inum, pc, reg, rval, addr, mval}.
  function automatic int rec_w(input int cnt_w);
    return PAYLOAD_W + cnt_w;
  endfunction

  // Fields irrelevant to the chosen kind stay zero.
  function automatic payload_t classify(
    input logic        reg_write,
    input logic        mem_read,
    input logic        mem_write,
    input logic        halt,
    input logic [15:0] pc,
    input logic [2:0]  write_reg,
    input logic [15:0] write_data,
    input logic [15:0] mem_addr,
    input logic [15:0] mem_data
  );
    payload_t p;
    p    = '0;
    p.pc = pc;
    if (reg_write) begin
      p.rd   = write_reg;
      p.rval = write_data;
      if (mem_write) begin
        p.kind = KIND_STU;
        p.addr = mem_addr;
        p.mval = mem_data;
      end else if (mem_read) begin
        p.kind = KIND_LD;
        p.addr = mem_addr;
      end else begin
        p.kind = KIND_REG;
      end
    end else if (halt) begin
      p.kind = KIND_HALT;
    end else if (mem_write) begin
      p.kind = KIND_ST;
      p.addr = mem_addr;
      p.mval = mem_data;
    end else begin
      p.kind = KIND_NOP;
    end
    return p;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty. Output data reads
// as zero while empty; a push into a full FIFO is accepted only alongside a pop.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_accept,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             full, do_pop, do_push;

  assign empty       = (wr_q == rd_q);
  assign full        = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop      = pop & ~empty;
  assign push_accept = ~full | do_pop;
  assign do_push     = push & push_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + (AW+1)'(1);
      if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: classifies each committed instruction, numbers it and
// queues a record toward a valid/ready trace sink; tracks cycles, drops and halt.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [15:0]      pc,
  input  logic [15:0]      inst,
  input  logic             reg_write,
  input  logic [2:0]       write_reg,
  input  logic [15:0]      write_data,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [15:0]      mem_addr,
  input  logic [15:0]      mem_data,
  input  logic             halt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_kind,
  output logic [CNT_W-1:0] out_inum,
  output logic [15:0]      out_pc,
  output logic [2:0]       out_reg,
  output logic [15:0]      out_rval,
  output logic [15:0]      out_addr,
  output logic [15:0]      out_mval,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] dropped,
  output logic             overflow,
  output logic             done,
  output state_t           dbg_state
);
  localparam int REC_W = rec_w(CNT_W);

  // Handshake: a record transfers on a cycle where out_valid & out_ready are
  // both high; while out_valid=1 and out_ready=0 the record is held unchanged.

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d, drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      held_pc_q, held_pc_d;
  payload_t         cur, rec_pl;
  logic             push, push_acc, fifo_empty, pop;
  logic [REC_W-1:0] push_rec, pop_rec;
  logic             unused_inst;

  // The instruction word is not part of the record.
  assign unused_inst = ^inst;

  assign cur = classify(reg_write, mem_read, mem_write, halt, pc,
                        write_reg, write_data, mem_addr, mem_data);

  always_comb begin
    state_d   = state_q;
    cycle_d   = cycle_q;
    inst_d    = inst_q;
    drop_d    = drop_q;
    ovf_d     = ovf_q;
    held_pc_d = held_pc_q;
    push      = 1'b0;
    rec_pl    = cur;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (en) begin
          push = 1'b1;
          if (cur.kind == KIND_HALT && !push_acc) begin
            // HALT is never dropped: park it and freeze the counters.
            state_d   = ST_HALT_PEND;
            held_pc_d = pc;
          end else begin
            cycle_d = cycle_q + 1'b1;
            inst_d  = inst_q + 1'b1;
            if (cur.kind == KIND_HALT) begin
              state_d = ST_DRAIN;
            end else if (!push_acc) begin
              ovf_d = 1'b1;
              if (drop_q != '1) drop_d = drop_q + 1'b1;
            end
          end
        end
      end
      ST_HALT_PEND: begin
        push        = 1'b1;
        rec_pl      = '0;
        rec_pl.kind = KIND_HALT;
        rec_pl.pc   = held_pc_q;
        if (push_acc) begin
          cycle_d = cycle_q + 1'b1;
          inst_d  = inst_q + 1'b1;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (fifo_empty) state_d = ST_DONE;
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cycle_q   <= '0;
      inst_q    <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
      held_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      cycle_q   <= cycle_d;
      inst_q    <= inst_d;
      drop_q    <= drop_d;
      ovf_q     <= ovf_d;
      held_pc_q <= held_pc_d;
    end
  end

  assign push_rec = {rec_pl.kind, inst_q, rec_pl.pc, rec_pl.rd,
                     rec_pl.rval, rec_pl.addr, rec_pl.mval};
  assign pop      = out_ready;

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_data  (push_rec),
    .push_accept(push_acc),
    .pop        (pop),
    .pop_data   (pop_rec),
    .empty      (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign {out_kind, out_inum, out_pc, out_reg, out_rval, out_addr, out_mval} = pop_rec;

  assign cycle_count = cycle_q;
  assign inst_count  = inst_q;
  assign dropped     = drop_q;
  assign overflow    = ovf_q;
  assign done        = (state_q == ST_DONE);
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed and random commit streams scored
// against a queue-based model of the trace rules.
module tb_commit_trace_buffer;
  import commit_trace_pkg::*;

  localparam int DEPTH = 16;
  localparam int CNT_W = 32;
  localparam int RW    = 70 + CNT_W;

  logic             clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [15:0]      pc = '0, inst = '0, write_data = '0, mem_addr = '0, mem_data = '0;
  logic             reg_write = 1'b0, mem_read = 1'b0, mem_write = 1'b0, halt = 1'b0;
  logic [2:0]       write_reg = '0;
  logic             out_ready = 1'b0;
  logic             out_valid, overflow, done;
  logic [2:0]       out_kind, out_reg;
  logic [CNT_W-1:0] out_inum, cycle_count, inst_count, dropped;
  logic [15:0]      out_pc, out_rval, out_addr, out_mval;
  state_t           dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] obs_q[$];
  int            obs_base = 0;
  int            chk_idx  = 0;

  // Reference model state
  int               m_occ;
  bit               m_started, m_pend, m_halted, m_ovf;
  logic [CNT_W-1:0] m_icnt, m_drop;
  logic [15:0]      m_hpc;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .pc(pc), .inst(inst),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_data(mem_data), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_inum(out_inum), .out_pc(out_pc), .out_reg(out_reg),
    .out_rval(out_rval), .out_addr(out_addr), .out_mval(out_mval),
    .cycle_count(cycle_count), .inst_count(inst_count), .dropped(dropped),
    .overflow(overflow), .done(done), .dbg_state(dbg_state)
  );

  // Record every transfer the sink accepts.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready)
      obs_q.push_back({out_kind, out_inum, out_pc, out_reg, out_rval, out_addr, out_mval});
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [RW-1:0] mk(input logic [2:0] k, input logic [CNT_W-1:0] n,
                                       input logic [15:0] p, input logic [2:0] r,
                                       input logic [15:0] rv, input logic [15:0] ad,
                                       input logic [15:0] mv);
    return {k, n, p, r, rv, ad, mv};
  endfunction

  // Drive one cycle of inputs, advance the model, then step past the edge.
  task automatic step(input bit e, input bit rdy, input bit rw, input bit mr, input bit mw,
                      input bit hl, input logic [15:0] p, input logic [2:0] wr,
                      input logic [15:0] wd, input logic [15:0] ma, input logic [15:0] md);
    bit pop, acc;
    logic [2:0] k, frg;
    logic [15:0] frv, fad, fmv;
    en = e; out_ready = rdy; reg_write = rw; mem_read = mr; mem_write = mw; halt = hl;
    pc = p; write_reg = wr; write_data = wd; mem_addr = ma; mem_data = md;
    inst = 16'($urandom);
    pop = rdy && (m_occ > 0);
    acc = (m_occ < DEPTH) || pop;
    if (!m_started) begin
      m_started = e;
    end else if (m_halted) begin
      m_occ = m_occ;
    end else if (m_pend) begin
      if (acc) begin
        exp_q.push_back(mk(3'd4, m_icnt, m_hpc, 3'd0, 16'd0, 16'd0, 16'd0));
        m_occ++; m_icnt = m_icnt + 1; m_pend = 0; m_halted = 1;
      end
    end else if (e) begin
      if (rw && mw)      k = 3'd2;
      else if (rw && mr) k = 3'd1;
      else if (rw)       k = 3'd0;
      else if (hl)       k = 3'd4;
      else if (mw)       k = 3'd3;
      else               k = 3'd5;
      frg = (k <= 3'd2) ? wr : 3'd0;
      frv = (k <= 3'd2) ? wd : 16'd0;
      fad = (k == 3'd1 || k == 3'd2 || k == 3'd3) ? ma : 16'd0;
      fmv = (k == 3'd2 || k == 3'd3) ? md : 16'd0;
      if (acc) begin
        exp_q.push_back(mk(k, m_icnt, p, frg, frv, fad, fmv));
        m_occ++; m_icnt = m_icnt + 1;
        if (k == 3'd4) m_halted = 1;
      end else if (k == 3'd4) begin
        m_pend = 1; m_hpc = p;
      end else begin
        m_icnt = m_icnt + 1; m_ovf = 1;
        if (m_drop != '1) m_drop = m_drop + 1;
      end
    end
    if (pop) m_occ--;
    @(posedge clk); #1;
  endtask

  task automatic nop(input bit e, input bit rdy);
    step(e, rdy, 0, 0, 0, 0, 16'($urandom), 3'($urandom), 16'($urandom),
         16'($urandom), 16'($urandom));
  endtask

  task automatic rnd(input bit e, input bit rdy);
    bit rw;
    rw = 1'($urandom);
    step(e, rdy, rw, 1'($urandom), 1'($urandom), rw & 1'($urandom), 16'($urandom),
         3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic drain();
    int budget;
    budget = 4 * DEPTH;
    while ((m_occ > 0 || m_pend) && budget > 0) begin
      nop(0, 1);
      budget--;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    m_occ = 0; m_started = 0; m_pend = 0; m_halted = 0; m_ovf = 0;
    m_icnt = '0; m_drop = '0; m_hpc = '0;
    exp_q.delete();
    obs_base = obs_q.size();
    chk_idx  = 0;
  endtask

  task automatic test_reset();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if (cycle_count !== '0 || inst_count !== '0 || dropped !== '0) begin
      n_fail++; $display("FAIL reset_counters got %0d/%0d/%0d want 0/0/0", cycle_count, inst_count, dropped); end
    n_checks++; if ({out_kind, out_inum, out_pc, out_reg, out_rval, out_addr, out_mval} !== '0) begin
      n_fail++; $display("FAIL reset_payload got pc=%h inum=%0d want all 0", out_pc, out_inum); end
    n_checks++; if (dbg_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE); end
  endtask

  task automatic test_basic();
    nop(1, 1);
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_idle_valid got %b want 0", out_valid); end
    step(1, 1, 1, 0, 0, 0, 16'h0100, 3'd3, 16'h0042, 16'($urandom), 16'($urandom));
    n_checks++; if (out_valid !== 1'b1 || out_kind !== 3'd0 || out_inum !== '0 || out_rval !== 16'h0042 || out_addr !== 16'd0) begin
      n_fail++; $display("FAIL basic_first got v=%b k=%0d n=%0d rv=%h ad=%h want 1/0/0/0042/0000", out_valid, out_kind, out_inum, out_rval, out_addr); end
    step(1, 1, 0, 0, 1, 0, 16'h0102, 3'($urandom), 16'($urandom), 16'h0010, 16'hBEEF);
    nop(1, 1);
    drain();
    n_checks++; if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL basic_count got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[obs_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_rec[%0d] got %h want %h", i, obs_q[obs_base+i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_stu_ld();
    step(1, 1, 1, 0, 1, 0, 16'h0200, 3'd2, 16'h1000, 16'h1000, 16'h0007);
    n_checks++; if (out_kind !== 3'd2 || out_mval !== 16'h0007 || out_reg !== 3'd2) begin
      n_fail++; $display("FAIL stu_fields got k=%0d mv=%h r=%0d want 2/0007/2", out_kind, out_mval, out_reg); end
    step(1, 1, 1, 1, 0, 0, 16'h0201, 3'd5, 16'h1234, 16'h2000, 16'h5555);
    n_checks++; if (out_kind !== 3'd1 || out_addr !== 16'h2000 || out_mval !== 16'd0) begin
      n_fail++; $display("FAIL ld_fields got k=%0d ad=%h mv=%h want 1/2000/0000", out_kind, out_addr, out_mval); end
    drain();
    n_checks++; if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL stu_ld_count got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[obs_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL stu_ld_rec[%0d] got %h want %h", i, obs_q[obs_base+i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_halt_reg();
    step(1, 1, 1, 0, 0, 1, 16'h0300, 3'd4, 16'h0ABC, 16'($urandom), 16'($urandom));
    n_checks++; if (out_kind !== 3'd0 || dbg_state !== ST_RUN) begin
      n_fail++; $display("FAIL halt_reg got k=%0d st=%0d want 0/%0d", out_kind, dbg_state, ST_RUN); end
    rnd(1, 1);
    drain();
    n_checks++; if (inst_count !== m_icnt) begin n_fail++; $display("FAIL halt_reg_icnt got %0d want %0d", inst_count, m_icnt); end
    for (int i = chk_idx; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[obs_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL halt_reg_rec[%0d] got %h want %h", i, obs_q[obs_base+i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH + 3; i++) begin
      nop(1, 0);
      n_checks++; if ({out_kind, out_inum, out_pc, out_reg, out_rval, out_addr, out_mval} !== exp_q[chk_idx]) begin
        n_fail++; $display("FAIL ovf_hold[%0d] got %h want %h", i, {out_kind, out_inum, out_pc, out_reg, out_rval, out_addr, out_mval}, exp_q[chk_idx]); end
    end
    n_checks++; if (dropped !== 32'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_drop got %0d/%b want 3/1", dropped, overflow); end
    n_checks++; if (inst_count !== m_icnt || cycle_count !== m_icnt) begin
      n_fail++; $display("FAIL ovf_counts got %0d/%0d want %0d", inst_count, cycle_count, m_icnt); end
    drain();
    n_checks++; if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL ovf_count got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[obs_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL ovf_rec[%0d] got %h want %h", i, obs_q[obs_base+i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++)
      rnd($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0);
    drain();
    n_checks++; if (inst_count !== m_icnt || cycle_count !== m_icnt) begin
      n_fail++; $display("FAIL rand_counts got %0d/%0d want %0d", inst_count, cycle_count, m_icnt); end
    n_checks++; if (dropped !== m_drop || overflow !== m_ovf) begin
      n_fail++; $display("FAIL rand_drop got %0d/%b want %0d/%b", dropped, overflow, m_drop, m_ovf); end
    n_checks++; if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[obs_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_rec[%0d] got %h want %h", i, obs_q[obs_base+i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_halt_pend();
    int budget;
    repeat (DEPTH) nop(1, 0);
    step(1, 0, 0, 1, 1, 1, 16'h0ACE, 3'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    n_checks++; if (dbg_state !== ST_HALT_PEND) begin n_fail++; $display("FAIL hp_state got %0d want %0d", dbg_state, ST_HALT_PEND); end
    repeat (3) rnd(1, 0);
    n_checks++; if (inst_count !== m_icnt || cycle_count !== m_icnt) begin
      n_fail++; $display("FAIL hp_frozen got %0d/%0d want %0d", inst_count, cycle_count, m_icnt); end
    drain();
    budget = 6;
    while (done !== 1'b1 && budget > 0) begin nop(1, 1); budget--; end
    n_checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL hp_done got %b/%b want 1/0", done, out_valid); end
    n_checks++; if (inst_count !== m_icnt) begin n_fail++; $display("FAIL hp_icnt got %0d want %0d", inst_count, m_icnt); end
    n_checks++; if (obs_q.size() - obs_base != exp_q.size()) begin n_fail++; $display("FAIL hp_count got %0d want %0d", obs_q.size() - obs_base, exp_q.size()); end
    for (int i = chk_idx; i < exp_q.size() && obs_base + i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[obs_base+i] !== exp_q[i]) begin n_fail++; $display("FAIL hp_rec[%0d] got %h want %h", i, obs_q[obs_base+i], exp_q[i]); end
    end
    chk_idx = exp_q.size();
  endtask

  task automatic test_reset_mid();
    do_reset();
    nop(1, 0);
    repeat (DEPTH + 1) rnd(1, 0);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL rm_pre_ovf got %b want 1", overflow); end
    repeat (DEPTH - 5) nop(0, 1);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre_valid got %b want 1", out_valid); end
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || overflow !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rm_flags got %b/%b/%b want 0/0/0", out_valid, overflow, done); end
    n_checks++; if (cycle_count !== '0 || inst_count !== '0 || dropped !== '0) begin
      n_fail++; $display("FAIL rm_counters got %0d/%0d/%0d want 0/0/0", cycle_count, inst_count, dropped); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL rm_after got %b/%0d want 0/%0d", out_valid, dbg_state, ST_IDLE); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_stu_ld();
    test_halt_reg();
    test_overflow();
    test_random();
    test_halt_pend();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Hardware commit-trace capture for the unpipelined core.
- Consumes the same per-cycle commit signals the simulation bench probes (PC, Inst, register write, memory access, Halt).
- Each cycle it classifies the commit, numbers it and queues a trace record in a FIFO. The FIFO drains over a valid/ready port toward a debug/trace sink.
- Also maintains cycle and instruction counters and detects end of program.

Parameters:
- DEPTH, 16, FIFO entries (power of two, ≥2)
- CNT_W, 32, width of cycle_count and inum counters

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- en  in  1  capture enable; sampled each cycle
- pc  in  16  PC of committing instruction
- inst  in  16  committing instruction word
- reg_write  in  1  register file written this cycle
- write_reg  in  3  destination register
- write_data  in  16  register write value
- mem_read  in  1  memory read this cycle
- mem_write  in  1  memory write this cycle
- mem_addr  in  16  memory address
- mem_data  in  16  memory write data
- halt  in  1  halt reached memory stage
- out_valid  out  1  record available
- out_ready  in  1  sink accepts record
- out_kind  out  3  record kind
- out_inum  out  CNT_W  instruction number
- out_pc, out_reg, out_rval, out_addr, out_mval  out  16/3/16/16/16  record payload
- cycle_count  out  CNT_W  cycles spent in RUN
- inst_count  out  CNT_W  records generated
- dropped  out  CNT_W  records lost to overflow (saturating)
- overflow  out  1  sticky; set on first drop
- done  out  1  halt record drained, FIFO empty

Behaviour:
- Reset (rst low, async): state IDLE; all counters 0; FIFO empty; out_valid/overflow/done 0; payload outputs 0.
- States: IDLE -> RUN when en=1. RUN -> HALT_PEND when a HALT record cannot be pushed (FIFO full, no pop). RUN or HALT_PEND -> DRAIN once the HALT record is pushed. DRAIN -> DONE when FIFO empty. DONE holds until reset. en=0 in RUN pauses capture and counting; the FIFO still drains.
- Classification in RUN, priority order:
  - reg_write & mem_write -> STU(2)
  - reg_write & mem_read -> LD(1)
  - reg_write -> REG(0)
  - halt -> HALT(4)
  - mem_write -> ST(3)
  - otherwise NOP(5); conditional branches are included here.
- reg_write together with halt produces a REG-class record, not HALT. Capture continues in that case.
- Exactly one record per RUN cycle. inum equals inst_count before the increment, so the first record has inum 0. inst_count and cycle_count each increment once per RUN cycle.
- Payload fields not relevant to the kind are forced to 0: NOP/HALT carry pc only; ST carries addr and mval; REG carries reg and rval; LD adds addr; STU carries all fields.
- Push latency: the record is registered at the RUN-cycle edge. out_valid rises the next cycle when the FIFO was empty; no fall-through.
- Handshake: a pop occurs on out_valid & out_ready. Payload must stay stable while out_valid=1 and out_ready=0.
- Full with simultaneous push and pop: both succeed, occupancy unchanged.
- Full, push, no pop, non-HALT record:
  - record dropped; dropped increments, saturating at all-ones; overflow set
  - inst_count still increments, so inum gaps remain visible downstream
- HALT is never dropped. In HALT_PEND the record is held and counters freeze until a slot frees.
- Input sampling stops after the HALT record; inputs are ignored in DRAIN and DONE.
- Pointers wrap modulo DEPTH. Occupancy uses an extra pointer bit to distinguish full from empty.
- Reset mid-operation: immediate return to reset values; queued records are discarded.

Decomposition:
- Package commit_trace_pkg: kind encodings REG/LD/STU/ST/HALT/NOP, the record struct/width (3 + CNT_W + 16 + 3 + 16 + 16 + 16), and the state encodings.
- Sub-module trace_fifo: synchronous FIFO with a DEPTH parameter and push/pop/full/empty signals. The classifier, counters and FSM stay in the top level.

Test Plan:
- Reset, en=1, three cycles: REG (r3=0x0042), ST (addr 0x0010, data 0xBEEF), NOP; out_ready=1 -> records kind 0/3/5, inum 0/1/2, fields as given, unused fields 0.
- Cycle with reg_write=1, mem_write=1, mem_read=0 (stu, r2=0x1000, addr 0x1000, data 0x0007) -> STU record. Cycle with reg_write=1, mem_read=1 -> LD record with addr, mval=0.
- out_ready=0, DEPTH+3 NOP cycles -> DEPTH records held, dropped=3, overflow=1, inst_count=DEPTH+3. Then out_ready=1 -> inums 0..DEPTH-1 in order.
- FIFO full, out_ready=0, halt=1 -> HALT_PEND, counters frozen. Release out_ready -> HALT record with correct inum appears last, done=1 after drain.
- halt=1 with reg_write=1 -> REG record, capture continues. A later halt-only cycle -> HALT record.
- Assert rst mid-drain with 5 records queued -> out_valid=0 immediately; counters, overflow and done all 0.
